// File: rtl/approx_pkg.sv
// Shared widths, FSM encoding and default abort budget for the approx core stream front-end.
package approx_pkg;

  localparam int Q_W         = 16;
  localparam int Q_FRAC      = 12;
  localparam int NIT_W       = 3;
  localparam int DEF_TIMEOUT = 255;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } state_t;

endpackage

// File: rtl/approx_fifo.sv
// Synchronous FIFO with occupancy output; read data is the combinational head entry.
// Pushes are dropped while full and pops are ignored while empty, so callers may request blindly.
module approx_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_W-1:0]        wr_data,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       cnt;
  logic              do_push;
  logic              do_pop;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];
  assign level   = cnt;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  // DEPTH is a power of two, so pointer overflow is the wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/approx_feeder.sv
// Feeds buffered Q4.12 samples to the approx core one at a time and returns results in order.
// Start follows a push by two cycles at best; input stalls when the FIFO is full, results hold until m_ready_i.
module approx_feeder #(
  parameter int DATA_W     = approx_pkg::Q_W,
  parameter int NIT_W      = approx_pkg::NIT_W,
  parameter int FIFO_DEPTH = 8,
  parameter int TIMEOUT    = approx_pkg::DEF_TIMEOUT
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DATA_W-1:0]             s_data_i,
  input  logic                          s_valid_i,
  output logic                          s_ready_o,
  input  logic [NIT_W-1:0]              cfg_nit_i,
  output logic [DATA_W-1:0]             core_x_o,
  output logic [NIT_W-1:0]              core_nit_o,
  output logic                          core_start_o,
  input  logic                          core_busy_i,
  input  logic [DATA_W-1:0]             core_y_i,
  input  logic                          core_valid_i,
  output logic [DATA_W-1:0]             m_data_o,
  output logic                          m_valid_o,
  input  logic                          m_ready_i,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  output logic                          err_timeout_o
);

  import approx_pkg::*;

  localparam int TW = $clog2(TIMEOUT + 1);

  state_t            state;
  state_t            state_nxt;
  logic [TW-1:0]     timer;
  logic              timer_done;
  logic [DATA_W-1:0] fifo_head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              pop;

  assign s_ready_o  = !fifo_full;
  assign timer_done = (timer == TW'(TIMEOUT));

  approx_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (s_valid_i),
    .pop     (pop),
    .wr_data (s_data_i),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level_o)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    pop          = 1'b0;
    core_start_o = 1'b0;
    unique case (state)
      IDLE: begin
        if (!fifo_empty && !core_busy_i) begin
          pop       = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        core_start_o = 1'b1;
        state_nxt    = WAIT;
      end
      WAIT: begin
        // A result arriving on the timeout cycle is still delivered.
        if (core_valid_i)    state_nxt = HOLD;
        else if (timer_done) state_nxt = IDLE;
      end
      HOLD: begin
        if (m_ready_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_x_o      <= '0;
      core_nit_o    <= '0;
      m_data_o      <= '0;
      m_valid_o     <= 1'b0;
      err_timeout_o <= 1'b0;
      timer         <= '0;
    end else begin
      // Operands stay put until the next issue so the core sees them for the whole job.
      if (pop) begin
        core_x_o   <= fifo_head;
        core_nit_o <= cfg_nit_i;
      end
      case (state)
        ISSUE: timer <= '0;
        WAIT: begin
          timer <= timer + 1'b1;
          if (core_valid_i) begin
            m_data_o  <= core_y_i;
            m_valid_o <= 1'b1;
          end else if (timer_done) begin
            err_timeout_o <= 1'b1;
          end
        end
        HOLD: begin
          if (m_ready_i) m_valid_o <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_approx_feeder.sv
// Directed bench for approx_feeder with a behavioural core stub returning y = x + nIt after a fixed latency.
module tb_approx_feeder;

  localparam int DATA_W     = 16;
  localparam int NIT_W      = 3;
  localparam int FIFO_DEPTH = 8;
  localparam int TIMEOUT    = 255;
  localparam int LW         = $clog2(FIFO_DEPTH) + 1;
  localparam int CORE_LAT   = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [DATA_W-1:0] s_data_i = '0;
  logic              s_valid_i = 1'b0;
  logic              s_ready_o;
  logic [NIT_W-1:0]  cfg_nit_i = 3'd7;
  logic [DATA_W-1:0] core_x_o;
  logic [NIT_W-1:0]  core_nit_o;
  logic              core_start_o;
  logic              core_busy_i;
  logic [DATA_W-1:0] core_y_i;
  logic              core_valid_i;
  logic [DATA_W-1:0] m_data_o;
  logic              m_valid_o;
  logic              m_ready_i = 1'b0;
  logic [LW-1:0]     fifo_level_o;
  logic              err_timeout_o;

  always #5 clk = ~clk;

  approx_feeder #(
    .DATA_W     (DATA_W),
    .NIT_W      (NIT_W),
    .FIFO_DEPTH (FIFO_DEPTH),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_data_i      (s_data_i),
    .s_valid_i     (s_valid_i),
    .s_ready_o     (s_ready_o),
    .cfg_nit_i     (cfg_nit_i),
    .core_x_o      (core_x_o),
    .core_nit_o    (core_nit_o),
    .core_start_o  (core_start_o),
    .core_busy_i   (core_busy_i),
    .core_y_i      (core_y_i),
    .core_valid_i  (core_valid_i),
    .m_data_o      (m_data_o),
    .m_valid_o     (m_valid_o),
    .m_ready_i     (m_ready_i),
    .fifo_level_o  (fifo_level_o),
    .err_timeout_o (err_timeout_o)
  );

  // Core stub: busy for CORE_LAT cycles after start, then a one-cycle valid unless muted.
  logic              stub_busy;
  logic              stub_valid;
  logic [DATA_W-1:0] stub_y;
  int                stub_cnt;
  logic              mute = 1'b0;
  logic              inj_valid = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stub_busy  <= 1'b0;
      stub_valid <= 1'b0;
      stub_y     <= '0;
      stub_cnt   <= 0;
    end else begin
      stub_valid <= 1'b0;
      if (core_start_o) begin
        stub_busy <= 1'b1;
        stub_cnt  <= CORE_LAT;
        stub_y    <= core_x_o + DATA_W'(core_nit_o);
      end else if (stub_busy) begin
        if (stub_cnt == 1) begin
          stub_busy  <= 1'b0;
          stub_valid <= !mute;
        end
        stub_cnt <= stub_cnt - 1;
      end
    end
  end

  assign core_busy_i  = stub_busy;
  assign core_y_i     = stub_y;
  assign core_valid_i = stub_valid | inj_valid;

  int                start_cnt = 0;
  logic [DATA_W-1:0] res_q[$];

  always @(posedge clk) begin
    if (core_start_o) start_cnt <= start_cnt + 1;
    if (rst_n && m_valid_o && m_ready_i) res_q.push_back(m_data_o);
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  // Called just after a negedge; returns just after the negedge following acceptance.
  task automatic push(input logic [DATA_W-1:0] x);
    s_data_i  = x;
    s_valid_i = 1'b1;
    for (int n = 0; n < 2000; n++) begin
      if (s_ready_o) begin
        @(negedge clk);
        s_valid_i = 1'b0;
        return;
      end
      @(negedge clk);
    end
    s_valid_i = 1'b0;
    check("push_timeout", 0, 1);
  endtask

  task automatic wait_start(input string name);
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (core_start_o) return;
    end
    check(name, 0, 1);
  endtask

  task automatic wait_valid(input string name);
    for (int n = 0; n < 600; n++) begin
      if (m_valid_o) return;
      @(negedge clk);
    end
    check(name, 0, 1);
  endtask

  task automatic wait_results(input int cnt, input string name);
    for (int n = 0; n < 2000; n++) begin
      if (res_q.size() >= cnt) return;
      @(negedge clk);
    end
    check(name, res_q.size(), cnt);
  endtask

  typedef struct {
    logic [DATA_W-1:0] x;
    logic [NIT_W-1:0]  nit;
    logic [DATA_W-1:0] exp_y;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    logic ok;
    logic bad;
    logic saw_full;

    vecs[0] = '{x: 16'd4096,  nit: 3'd0, exp_y: 16'd4096};
    vecs[1] = '{x: 16'hFFFF,  nit: 3'd1, exp_y: 16'h0000};
    vecs[2] = '{x: 16'h8000,  nit: 3'd3, exp_y: 16'h8003};
    vecs[3] = '{x: 16'd12,    nit: 3'd5, exp_y: 16'd17};
    vecs[4] = '{x: 16'h7FF8,  nit: 3'd7, exp_y: 16'h7FFF};
    vecs[5] = '{x: 16'd0,     nit: 3'd2, exp_y: 16'd2};

    // 1: reset state and clean release
    repeat (5) @(negedge clk);
    check("rst_m_valid", m_valid_o, 0);
    check("rst_m_data", m_data_o, 0);
    check("rst_start", core_start_o, 0);
    check("rst_core_x", core_x_o, 0);
    check("rst_core_nit", core_nit_o, 0);
    check("rst_err", err_timeout_o, 0);
    check("rst_s_ready", s_ready_o, 1);
    check("rst_level", fifo_level_o, 0);
    rst_n = 1'b1;
    s0 = start_cnt;
    repeat (5) @(negedge clk);
    check("rel_no_start", start_cnt - s0, 0);

    // Spurious core valid while idle must be ignored
    res_q.delete();
    m_ready_i = 1'b1;
    inj_valid = 1'b1;
    @(negedge clk);
    inj_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("spur_m_valid", m_valid_o, 0);
    check("spur_err", err_timeout_o, 0);
    check("spur_no_result", res_q.size(), 0);

    // 2: single sample, latency, hold and backpressure
    m_ready_i = 1'b0;
    cfg_nit_i = 3'd7;
    s0 = start_cnt;
    push(16'd3277);
    check("t2_no_early_start", core_start_o, 0);
    @(negedge clk);
    check("t2_start_latency", core_start_o, 1);
    check("t2_core_x", core_x_o, 3277);
    check("t2_core_nit", core_nit_o, 7);
    ok = 1'b1;
    for (int n = 0; n < 100; n++) begin
      if (m_valid_o) break;
      if (core_x_o != 16'd3277) ok = 1'b0;
      @(negedge clk);
    end
    check("t2_valid_seen", m_valid_o, 1);
    check("t2_x_held", ok, 1);
    check("t2_m_data", m_data_o, 3284);
    ok = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (!m_valid_o || m_data_o != 16'd3284) ok = 1'b0;
    end
    check("t2_hold", ok, 1);
    check("t2_one_start", start_cnt - s0, 1);
    m_ready_i = 1'b1;
    @(negedge clk);
    m_ready_i = 1'b0;
    check("t2_release", m_valid_o, 0);

    // Table: per-sample nIt latched at issue, arithmetic pass-through incl. wrap
    m_ready_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cfg_nit_i = vecs[i].nit;
      push(vecs[i].x);
      wait_start($sformatf("tbl_start_%0d", i));
      check($sformatf("tbl_x_%0d", i), core_x_o, vecs[i].x);
      check($sformatf("tbl_nit_%0d", i), core_nit_o, vecs[i].nit);
      cfg_nit_i = ~vecs[i].nit;
      wait_valid($sformatf("tbl_valid_%0d", i));
      check($sformatf("tbl_y_%0d", i), m_data_o, vecs[i].exp_y);
      check($sformatf("tbl_nit_held_%0d", i), core_nit_o, vecs[i].nit);
      @(negedge clk);
    end

    // 3: burst of 12, FIFO fills, order preserved
    res_q.delete();
    cfg_nit_i = 3'd7;
    m_ready_i = 1'b1;
    saw_full  = 1'b0;
    bad       = 1'b0;
    fork
      begin
        for (int i = 1; i <= 12; i++) push(DATA_W'(i));
      end
      begin
        for (int n = 0; n < 1000; n++) begin
          @(negedge clk);
          if (fifo_level_o == LW'(FIFO_DEPTH) && !s_ready_o) saw_full = 1'b1;
          if (!s_ready_o && fifo_level_o != LW'(FIFO_DEPTH)) bad = 1'b1;
          if (res_q.size() >= 12) break;
        end
      end
    join
    check("t3_saw_full", saw_full, 1);
    check("t3_ready_only_when_full", bad, 0);
    check("t3_count", res_q.size(), 12);
    for (int i = 0; i < 12; i++)
      check($sformatf("t3_res_%0d", i), (i < res_q.size()) ? res_q[i] : 16'hDEAD, i + 8);

    // 4: long sink stall with FIFO loaded
    res_q.delete();
    m_ready_i = 1'b0;
    push(16'd500);
    push(16'd501);
    push(16'd502);
    wait_valid("t4_valid");
    s0 = start_cnt;
    ok = 1'b1;
    repeat (200) begin
      @(negedge clk);
      if (!m_valid_o || m_data_o != 16'd507) ok = 1'b0;
    end
    check("t4_stable", ok, 1);
    check("t4_no_start", start_cnt - s0, 0);
    check("t4_level", fifo_level_o, 2);
    m_ready_i = 1'b1;
    wait_results(3, "t4_drain");
    check("t4_res0", (res_q.size() > 0) ? res_q[0] : 16'hDEAD, 507);
    check("t4_res1", (res_q.size() > 1) ? res_q[1] : 16'hDEAD, 508);
    check("t4_res2", (res_q.size() > 2) ? res_q[2] : 16'hDEAD, 509);

    // 5: core never answers -> timeout, then normal recovery
    res_q.delete();
    mute = 1'b1;
    check("t5_err_clear", err_timeout_o, 0);
    push(16'd100);
    wait_start("t5_start");
    repeat (TIMEOUT + 1) @(negedge clk);
    check("t5_err_not_yet", err_timeout_o, 0);
    @(negedge clk);
    check("t5_err_set", err_timeout_o, 1);
    check("t5_no_valid", m_valid_o, 0);
    mute = 1'b0;
    push(16'd200);
    wait_valid("t5_valid");
    check("t5_recover_y", m_data_o, 207);
    @(negedge clk);
    check("t5_err_sticky", err_timeout_o, 1);
    check("t5_results", res_q.size(), 1);

    // 6: reset while waiting with samples queued
    mute = 1'b1;
    for (int i = 0; i < 6; i++) push(DATA_W'(1000 + i));
    @(negedge clk);
    check("t6_level_before", fifo_level_o, 5);
    check("t6_waiting", m_valid_o, 0);
    rst_n = 1'b0;
    #1;
    check("t6_level", fifo_level_o, 0);
    check("t6_m_valid", m_valid_o, 0);
    check("t6_err", err_timeout_o, 0);
    check("t6_start", core_start_o, 0);
    check("t6_s_ready", s_ready_o, 1);
    repeat (3) @(negedge clk);
    mute  = 1'b0;
    rst_n = 1'b1;
    s0 = start_cnt;
    repeat (5) @(negedge clk);
    check("t6_no_start", start_cnt - s0, 0);
    cfg_nit_i = 3'd7;
    push(16'd4096);
    wait_valid("t6_valid");
    check("t6_y", m_data_o, 4103);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
